// File: rtl/rca_operand_stage.sv
// Two-stage valid/ready wrapper around a WIDTH-bit ripple-carry adder.
// Stage 1 holds the operand pair, stage 2 holds the {carry, sum} result.
module rca_operand_stage #(
  parameter int WIDTH     = 6,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_add_term1,
  input  logic [WIDTH-1:0]     i_add_term2,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH:0]       o_result,
  input  logic                 i_clear,
  output logic [CNT_WIDTH-1:0] o_result_count,
  output logic [CNT_WIDTH-1:0] o_carry_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 r_s1_valid;
  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_op_a;
  logic [WIDTH-1:0]     r_op_b;
  logic [WIDTH:0]       r_result;
  logic [CNT_WIDTH-1:0] r_result_count;
  logic [CNT_WIDTH-1:0] r_carry_count;

  logic                 w_adv1;
  logic                 w_adv2;
  logic                 w_push;
  logic                 w_pop;
  logic [WIDTH:0]       w_sum;

  // Stall control depends only on occupancy and i_ready, never on i_valid.
  assign w_adv2  = !r_s2_valid || i_ready;
  assign w_adv1  = !r_s1_valid || w_adv2;
  assign w_push  = i_valid && w_adv1;
  assign w_pop   = r_s2_valid && i_ready;

  assign o_ready        = w_adv1;
  assign o_valid        = r_s2_valid;
  assign o_result       = r_result;
  assign o_result_count = r_result_count;
  assign o_carry_count  = r_carry_count;

  // Operand stage: capture only on an upstream transfer, hold otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_op_a     <= {WIDTH{1'b0}};
      r_op_b     <= {WIDTH{1'b0}};
    end else begin
      if (w_adv1) begin
        r_s1_valid <= i_valid;
      end else begin
        r_s1_valid <= r_s1_valid;
      end
      if (w_push) begin
        r_op_a <= i_add_term1;
        r_op_b <= i_add_term2;
      end else begin
        r_op_a <= r_op_a;
        r_op_b <= r_op_b;
      end
    end
  end

  // Bit-serial carry chain, carry-in tied low; the final carry is result MSB.
  always_comb begin : ripple_adder
    logic c;
    c     = 1'b0;
    w_sum = {(WIDTH+1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i] = r_op_a[i] ^ r_op_b[i] ^ c;
      c        = (r_op_a[i] & r_op_b[i]) | (c & (r_op_a[i] ^ r_op_b[i]));
    end
    w_sum[WIDTH] = c;
  end

  // Result stage: o_result only changes when a new sum moves in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= {(WIDTH+1){1'b0}};
    end else begin
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
      end else begin
        r_s2_valid <= r_s2_valid;
      end
      if (w_adv2 && r_s1_valid) begin
        r_result <= w_sum;
      end else begin
        r_result <= r_result;
      end
    end
  end

  // Statistics; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result_count <= CNT_ZERO;
      r_carry_count  <= CNT_ZERO;
    end else if (i_clear) begin
      r_result_count <= CNT_ZERO;
      r_carry_count  <= CNT_ZERO;
    end else if (w_pop) begin
      r_result_count <= r_result_count + CNT_ONE;
      if (r_result[WIDTH]) begin
        r_carry_count <= r_carry_count + CNT_ONE;
      end else begin
        r_carry_count <= r_carry_count;
      end
    end else begin
      r_result_count <= r_result_count;
      r_carry_count  <= r_carry_count;
    end
  end

endmodule

// File: tb/tb_rca_operand_stage.sv
// Randomized and directed bench for rca_operand_stage with a queue scoreboard
// and an arithmetic reference model of the sums and statistics counters.
module tb_rca_operand_stage;

  localparam int WIDTH     = 6;
  localparam int CNT_WIDTH = 8;

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic [WIDTH-1:0]     i_add_term1;
  logic [WIDTH-1:0]     i_add_term2;
  logic                 o_valid;
  logic                 i_ready;
  logic [WIDTH:0]       o_result;
  logic                 i_clear;
  logic [CNT_WIDTH-1:0] o_result_count;
  logic [CNT_WIDTH-1:0] o_carry_count;

  int n_cmp  = 0;
  int n_fail = 0;

  int                   exp_q[$];
  logic [CNT_WIDTH-1:0] m_count;
  logic [CNT_WIDTH-1:0] m_carry;
  logic                 held_v;
  int                   held_val;

  rca_operand_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_add_term1    (i_add_term1),
    .i_add_term2    (i_add_term2),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_result       (o_result),
    .i_clear        (i_clear),
    .o_result_count (o_result_count),
    .o_carry_count  (o_carry_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so the negedge
  // sees exactly what the coming edge will act on.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
      m_count = '0;
      m_carry = '0;
      held_v  = 1'b0;
      cmp("reset_o_valid", int'(o_valid), 0);
      cmp("reset_result_count", int'(o_result_count), 0);
      cmp("reset_carry_count", int'(o_carry_count), 0);
    end else begin
      cmp("o_ready", int'(o_ready), int'((exp_q.size() < 2) || i_ready));
      cmp("result_count", int'(o_result_count), int'(m_count));
      cmp("carry_count", int'(o_carry_count), int'(m_carry));
      if (held_v) begin
        cmp("stall_valid_held", int'(o_valid), 1);
        cmp("stall_result_held", int'(o_result), held_val);
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          cmp("spurious_result", int'(o_result), -1);
        end else if (i_ready) begin
          int e;
          e = exp_q.pop_front();
          cmp("result", int'(o_result), e);
          m_count = m_count + 1;
          if (e >= (1 << WIDTH)) m_carry = m_carry + 1;
        end
      end
      held_v   = o_valid && !i_ready;
      held_val = int'(o_result);
      if (i_clear) begin
        m_count = '0;
        m_carry = '0;
      end
      if (i_valid && o_ready) exp_q.push_back(int'(i_add_term1) + int'(i_add_term2));
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    int k;
    i_valid = 1'b0;
    i_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) cmp("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_clear = 1'b0;
    i_add_term1 = '0; i_add_term2 = '0;
    repeat (3) step();
    cmp("reset_o_result", int'(o_result), 0);
    i_rst_n = 1'b1;
    step();
    cmp("ready_after_reset", int'(o_ready), 1);

    // 63 + 1 carries out; visible two cycles after it is presented
    i_ready = 1'b1; i_valid = 1'b1; i_add_term1 = 6'd63; i_add_term2 = 6'd1;
    step();
    i_valid = 1'b0;
    cmp("latency_not_early", int'(o_valid), 0);
    step();
    cmp("latency_valid", int'(o_valid), 1);
    cmp("first_result", int'(o_result), 64);
    step();
    cmp("first_count", int'(o_result_count), 1);
    cmp("first_carry", int'(o_carry_count), 1);

    // Back-to-back 0+0 then 21+42
    i_valid = 1'b1; i_add_term1 = 6'd0; i_add_term2 = 6'd0;
    step();
    i_add_term1 = 6'd21; i_add_term2 = 6'd42;
    step();
    i_valid = 1'b0;
    cmp("b2b_first", int'(o_result), 0);
    step();
    cmp("b2b_second", int'(o_result), 63);
    drain();

    // Backpressure: third push must stall
    i_ready = 1'b0; i_valid = 1'b1; i_add_term1 = 6'd10; i_add_term2 = 6'd5;
    step();
    i_add_term1 = 6'd20;
    step();
    i_add_term1 = 6'd30;
    for (int i = 0; i < 3; i++) begin
      cmp("full_stall_ready", int'(o_ready), 0);
      cmp("full_stall_head", int'(o_result), 15);
      step();
    end
    i_ready = 1'b1;
    step();
    i_valid = 1'b0;
    drain();

    // Full pipeline with simultaneous push and pop: 63+63 every cycle
    i_valid = 1'b1; i_add_term1 = 6'd63; i_add_term2 = 6'd63;
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      cmp("stream_126", int'(o_result), 126);
      cmp("stream_valid", int'(o_valid), 1);
      step();
    end
    drain();

    // Reset with two pairs in flight
    i_ready = 1'b0; i_valid = 1'b1; i_add_term1 = 6'd7; i_add_term2 = 6'd9;
    step();
    step();
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    cmp("midreset_valid", int'(o_valid), 0);
    cmp("midreset_count", int'(o_result_count), 0);
    step();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    repeat (5) step();

    // 256 carry-producing results wrap both counters to zero
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    i_valid = 1'b1; i_add_term1 = 6'd32; i_add_term2 = 6'd32;
    repeat (256) step();
    i_valid = 1'b0;
    repeat (3) step();
    cmp("wrap_count", int'(o_result_count), 0);
    cmp("wrap_carry", int'(o_carry_count), 0);

    // Clear coinciding with a downstream transfer
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    cmp("clr_pending_valid", int'(o_valid), 1);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    cmp("clr_count", int'(o_result_count), 0);
    cmp("clr_carry", int'(o_carry_count), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      i_valid     = ($urandom_range(0, 3) != 0);
      i_ready     = ($urandom_range(0, 2) != 0);
      i_clear     = ($urandom_range(0, 40) == 0);
      i_add_term1 = WIDTH'($urandom);
      i_add_term2 = WIDTH'($urandom);
      step();
    end
    i_clear = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
